// File: rtl/i2c_pkg.sv
// Shared constants for the I2C byte-array target: FSM state codes,
// address width and the ACK/NACK levels on the bus and on the SDA drive enable.
package i2c_pkg;

    localparam int ADDR_W = 7;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ADDR     = 3'd1;
    localparam logic [2:0] S_ADDR_ACK = 3'd2;
    localparam logic [2:0] S_WR_BYTE  = 3'd3;
    localparam logic [2:0] S_WR_ACK   = 3'd4;
    localparam logic [2:0] S_RD_BYTE  = 3'd5;
    localparam logic [2:0] S_RD_ACK   = 3'd6;
    localparam logic [2:0] S_IGNORE   = 3'd7;

    // Level seen on the wire for an acknowledge / not-acknowledge.
    localparam logic BUS_ACK  = 1'b0;
    localparam logic BUS_NACK = 1'b1;

    // Open-drain enable values: 1 pulls SDA low (ACK), 0 releases it (NACK).
    localparam logic DRV_ACK  = 1'b1;
    localparam logic DRV_NACK = 1'b0;

endpackage

// File: rtl/i2c_bus_cond.sv
// Synchronises SCL/SDA into the clk domain and derives single-cycle
// SCL-rise, SCL-fall, START and STOP pulses from the synchronised levels.
module i2c_bus_cond #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic RESET,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_prev_q;
    logic                   sda_prev_q;
    logic                   scl_s;
    logic                   sda_s;

    // Synchroniser chains plus one history flop each; reset to the idle-bus level.
    always_ff @(posedge clk) begin
        if (RESET) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    assign sda_o      = sda_s;
    assign scl_rise_o = scl_s & ~scl_prev_q;
    assign scl_fall_o = ~scl_s & scl_prev_q;
    // SDA edges only count as conditions while SCL was high before and after.
    assign start_o    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_o     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_target_nb.sv
// I2C target exposing an NBYTES-wide write register and read payload.
// Writes commit atomically after the last byte's ACK; reads stream a
// shadow copy of RD_DATA captured when the read address phase ends.
module i2c_target_nb
    import i2c_pkg::*;
#(
    parameter int NBYTES      = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                RESET,
    input  logic                SCL,
    input  logic                SDA_OUT,
    input  logic [ADDR_W-1:0]   I2C_ADDR,
    input  logic [8*NBYTES-1:0] RD_DATA,
    output logic                SDA_IN,
    output logic [8*NBYTES-1:0] WR_DATA,
    output logic                WR_VALID,
    output logic                RD_LOAD,
    output logic                BUSY
);

    localparam int         PW      = 8 * NBYTES;
    localparam logic [3:0] NB      = 4'(NBYTES);
    localparam logic [3:0] NB_LAST = 4'(NBYTES - 1);

    logic          sda_s, scl_rise, scl_fall, start_c, stop_c;
    logic [2:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [3:0]    idx_q, idx_d;
    logic [7:0]    sr_q, sr_d;
    logic          rw_q, rw_d;
    logic          sda_q, sda_d;
    logic          busy_q, busy_d;
    logic          wr_valid_q, wr_valid_d;
    logic          rd_load_q, rd_load_d;
    logic [PW-1:0] wbuf_q, wbuf_d;
    logic [PW-1:0] wr_data_q, wr_data_d;
    logic [PW-1:0] shadow_q, shadow_d;

    i2c_bus_cond #(.SYNC_STAGES(SYNC_STAGES)) u_cond (
        .clk        (clk),
        .RESET      (RESET),
        .scl_i      (SCL),
        .sda_i      (SDA_OUT),
        .sda_o      (sda_s),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (start_c),
        .stop_o     (stop_c)
    );

    // Bit `bitn` (0 = MSB) of byte `idx` (0 = most significant byte) of data.
    function automatic logic rd_bit(input logic [PW-1:0] data, input logic [3:0] idx,
                                    input logic [3:0] bitn);
        logic [PW-1:0] msb;
        msb         = '0;
        msb[PW-1]   = 1'b1;
        return |(data & (msb >> ({1'b0, idx, 3'b000} + {4'b0000, bitn})));
    endfunction

    // Replace byte `idx` (0 = most significant byte) of buf with b.
    function automatic logic [PW-1:0] put_byte(input logic [PW-1:0] buf_in,
                                               input logic [3:0] idx, input logic [7:0] b);
        logic [PW-1:0] m;
        logic [PW-1:0] v;
        logic [7:0]    sh;
        m      = '0;
        v      = '0;
        m[7:0] = 8'hFF;
        v[7:0] = b;
        sh     = {1'b0, NB_LAST, 3'b000} - {1'b0, idx, 3'b000};
        return (buf_in & ~(m << sh)) | (v << sh);
    endfunction

    // Next-state logic: bits sampled on SCL rise, SDA drive updated on SCL fall.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        sr_d       = sr_q;
        rw_d       = rw_q;
        sda_d      = sda_q;
        busy_d     = busy_q;
        wbuf_d     = wbuf_q;
        wr_data_d  = wr_data_q;
        shadow_d   = shadow_q;
        wr_valid_d = 1'b0;
        rd_load_d  = 1'b0;

        if (scl_rise) begin
            sr_d = {sr_q[6:0], sda_s};
            if (state_q == S_ADDR || state_q == S_WR_BYTE || state_q == S_RD_BYTE)
                cnt_d = cnt_q + 4'd1;
        end

        if (scl_fall) begin
            case (state_q)
                S_ADDR: begin
                    if (cnt_q == 4'd8) begin
                        if (sr_q[7:1] == I2C_ADDR) begin
                            state_d = S_ADDR_ACK;
                            sda_d   = DRV_ACK;
                            rw_d    = sr_q[0];
                        end else begin
                            state_d = S_IGNORE;
                            sda_d   = DRV_NACK;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    cnt_d = 4'd0;
                    idx_d = 4'd0;
                    if (rw_q) begin
                        state_d   = S_RD_BYTE;
                        shadow_d  = RD_DATA;
                        rd_load_d = 1'b1;
                        sda_d     = ~RD_DATA[PW-1];
                    end else begin
                        state_d = S_WR_BYTE;
                        sda_d   = DRV_NACK;
                    end
                end
                S_WR_BYTE: begin
                    if (cnt_q == 4'd8) begin
                        state_d = S_WR_ACK;
                        cnt_d   = 4'd0;
                        if (idx_q < NB) begin
                            sda_d  = DRV_ACK;
                            wbuf_d = put_byte(wbuf_q, idx_q, sr_q);
                        end else begin
                            sda_d  = DRV_NACK;
                        end
                    end
                end
                S_WR_ACK: begin
                    state_d = S_WR_BYTE;
                    sda_d   = DRV_NACK;
                    if (idx_q == NB_LAST) begin
                        wr_data_d  = wbuf_q;
                        wr_valid_d = 1'b1;
                    end
                    if (idx_q < NB)
                        idx_d = idx_q + 4'd1;
                end
                S_RD_BYTE: begin
                    if (cnt_q == 4'd8) begin
                        state_d = S_RD_ACK;
                        cnt_d   = 4'd0;
                        sda_d   = DRV_NACK;
                    end else begin
                        sda_d   = ~rd_bit(shadow_q, idx_q, cnt_q);
                    end
                end
                S_RD_ACK: begin
                    if (sr_q[0] == BUS_ACK) begin
                        state_d = S_RD_BYTE;
                        idx_d   = (idx_q == NB_LAST) ? 4'd0 : idx_q + 4'd1;
                        sda_d   = ~rd_bit(shadow_q, idx_d, 4'd0);
                    end else begin
                        state_d = S_IGNORE;
                        sda_d   = DRV_NACK;
                    end
                end
                default: sda_d = DRV_NACK;
            endcase
        end

        // Bus conditions override whatever the current byte was doing.
        if (start_c) begin
            state_d = S_ADDR;
            cnt_d   = 4'd0;
            idx_d   = 4'd0;
            sda_d   = DRV_NACK;
            busy_d  = 1'b1;
        end else if (stop_c) begin
            state_d = S_IDLE;
            sda_d   = DRV_NACK;
            busy_d  = 1'b0;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            sr_q       <= '0;
            rw_q       <= 1'b0;
            sda_q      <= DRV_NACK;
            busy_q     <= 1'b0;
            wr_valid_q <= 1'b0;
            rd_load_q  <= 1'b0;
            wbuf_q     <= '0;
            wr_data_q  <= '0;
            shadow_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            sr_q       <= sr_d;
            rw_q       <= rw_d;
            sda_q      <= sda_d;
            busy_q     <= busy_d;
            wr_valid_q <= wr_valid_d;
            rd_load_q  <= rd_load_d;
            wbuf_q     <= wbuf_d;
            wr_data_q  <= wr_data_d;
            shadow_q   <= shadow_d;
        end
    end

    assign SDA_IN   = sda_q;
    assign WR_DATA  = wr_data_q;
    assign WR_VALID = wr_valid_q;
    assign RD_LOAD  = rd_load_q;
    assign BUSY     = busy_q;

endmodule

// File: tb/tb_i2c_target_nb.sv
// Bench for i2c_target_nb: a bit-banged I2C master on an open-drain wire,
// a directed transaction table, hand-written corner sequences and
// randomized transactions scored against a transaction-level model.
module tb_i2c_target_nb;

    localparam int         NB  = 2;
    localparam logic [6:0] OWN = 7'h2A;

    logic        clk = 1'b0;
    logic        RESET;
    logic        scl_m;
    logic        sda_m;
    logic        sda_wire;
    logic [6:0]  own_addr;
    logic [15:0] rd_data;
    logic        SDA_IN;
    logic [15:0] WR_DATA;
    logic        WR_VALID;
    logic        RD_LOAD;
    logic        BUSY;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign sda_wire = sda_m & ~SDA_IN;

    i2c_target_nb #(.NBYTES(NB), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .RESET    (RESET),
        .SCL      (scl_m),
        .SDA_OUT  (sda_wire),
        .I2C_ADDR (own_addr),
        .RD_DATA  (rd_data),
        .SDA_IN   (SDA_IN),
        .WR_DATA  (WR_DATA),
        .WR_VALID (WR_VALID),
        .RD_LOAD  (RD_LOAD),
        .BUSY     (BUSY)
    );

    // Bus monitor: pulse counters, SDA drive activity, and SDA changes during SCL high.
    int   wv_cnt = 0, rl_cnt = 0, drv_cnt = 0, viol = 0;
    logic sda_prev_mon = 1'b0, scl_prev_mon = 1'b1, rst_prev_mon = 1'b1;
    always @(posedge clk) begin
        if (SDA_IN != sda_prev_mon && scl_prev_mon && !rst_prev_mon) viol <= viol + 1;
        if (WR_VALID) wv_cnt <= wv_cnt + 1;
        if (RD_LOAD)  rl_cnt <= rl_cnt + 1;
        if (SDA_IN)   drv_cnt <= drv_cnt + 1;
        sda_prev_mon <= SDA_IN;
        scl_prev_mon <= scl_m;
        rst_prev_mon <= RESET;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic wt(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SCL period: drive b during SCL low, sample the wire mid-high.
    task automatic sbit(input logic b, output logic s);
        wt(4); sda_m = b;
        wt(4); scl_m = 1'b1;
        wt(4); s = sda_wire;
        wt(4); scl_m = 1'b0;
    endtask

    task automatic bus_start();
        wt(4); sda_m = 1'b1;
        wt(4); scl_m = 1'b1;
        wt(4); sda_m = 1'b0;
        wt(4); scl_m = 1'b0;
    endtask

    task automatic bus_stop();
        wt(4); sda_m = 1'b0;
        wt(4); scl_m = 1'b1;
        wt(4); sda_m = 1'b1;
        wt(8);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) sbit(d[i], s);
        sbit(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(output logic [7:0] b, input logic ack);
        logic s;
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            sbit(1'b1, s);
            b = {b[6:0], s};
        end
        sbit(~ack, s);
    endtask

    // Full transaction; reads ACK every byte except the last.
    task automatic txn(input logic [6:0] addr, input logic rw, input int n,
                       input logic [31:0] wb, input logic do_stop,
                       output logic aack, output logic [3:0] ackm, output logic [31:0] rb);
        logic       a;
        logic [7:0] b;
        ackm = 4'b0;
        rb   = 32'h0;
        bus_start();
        write_byte({addr, rw}, aack);
        for (int i = 0; i < n; i++) begin
            if (!rw) begin
                write_byte(wb[31-8*i -: 8], a);
                ackm[i] = a;
            end else begin
                read_byte(b, i != n - 1);
                rb[31-8*i -: 8] = b;
            end
        end
        if (do_stop) bus_stop();
    endtask

    // Transaction-level reference: what a correct target does for one transfer.
    logic [15:0] model_wr = 16'h0;
    task automatic model(input logic [6:0] addr, input logic rw, input int n,
                         input logic [31:0] wb, input logic [15:0] rd,
                         output logic aack, output logic [3:0] ackm, output logic [31:0] rb,
                         output int wv, output int rl);
        logic match;
        match = (addr == OWN);
        aack  = match;
        ackm  = 4'b0;
        rb    = 32'h0;
        wv    = 0;
        rl    = (rw && match) ? 1 : 0;
        for (int i = 0; i < n; i++) begin
            if (!rw) ackm[i] = match && (i < NB);
            else     rb[31-8*i -: 8] = !match ? 8'hFF : ((i % NB) == 0 ? rd[15:8] : rd[7:0]);
        end
        if (!rw && match && n >= NB) begin
            wv       = 1;
            model_wr = wb[31:16];
        end
    endtask

    typedef struct {
        logic [6:0]  addr;
        logic        rw;
        int          n;
        logic [31:0] wb;
        logic [15:0] rd;
        logic        exp_aack;
        logic [3:0]  exp_ackm;
        logic [15:0] exp_wr;
        int          exp_wv;
        int          exp_rl;
        logic [31:0] exp_rb;
    } vec_t;

    vec_t tbl[6];

    task automatic run_and_check(input string tag, input vec_t v);
        logic        aack;
        logic [3:0]  ackm;
        logic [31:0] rb;
        int          wv0, rl0, dr0;
        rd_data = v.rd;
        wv0 = wv_cnt; rl0 = rl_cnt; dr0 = drv_cnt;
        txn(v.addr, v.rw, v.n, v.wb, 1'b1, aack, ackm, rb);
        chk({tag, "_addr_ack"}, 32'(aack), 32'(v.exp_aack));
        chk({tag, "_byte_acks"}, 32'(ackm), 32'(v.exp_ackm));
        chk({tag, "_read_bytes"}, rb, v.exp_rb);
        chk({tag, "_wr_data"}, 32'(WR_DATA), 32'(v.exp_wr));
        chk({tag, "_wr_valid_cnt"}, wv_cnt - wv0, v.exp_wv);
        chk({tag, "_rd_load_cnt"}, rl_cnt - rl0, v.exp_rl);
        chk({tag, "_busy_after_stop"}, 32'(BUSY), 32'h0);
        if (!v.exp_aack) chk({tag, "_no_drive"}, drv_cnt - dr0, 0);
    endtask

    initial begin
        logic        aack;
        logic [3:0]  ackm;
        logic [31:0] rb;
        logic        s;
        int          wv0, rl0, dr0;
        vec_t        v;

        RESET = 1'b1; scl_m = 1'b1; sda_m = 1'b1; own_addr = OWN; rd_data = 16'h0;
        wt(4);
        chk("reset_outputs", {11'h0, SDA_IN, WR_VALID, RD_LOAD, BUSY, WR_DATA}, 32'h0);
        RESET = 1'b0;
        wt(4);

        tbl[0] = '{7'h2A, 1'b0, 2, 32'hBEEF0000, 16'h0000, 1'b1, 4'b0011, 16'hBEEF, 1, 0, 32'h0};
        tbl[1] = '{7'h2A, 1'b1, 2, 32'h0,        16'hA55A, 1'b1, 4'b0000, 16'hBEEF, 0, 1, 32'hA55A0000};
        tbl[2] = '{7'h2B, 1'b0, 1, 32'h77000000, 16'h0000, 1'b0, 4'b0000, 16'hBEEF, 0, 0, 32'h0};
        tbl[3] = '{7'h2A, 1'b0, 3, 32'h11223300, 16'h0000, 1'b1, 4'b0011, 16'h1122, 1, 0, 32'h0};
        tbl[4] = '{7'h2A, 1'b1, 3, 32'h0,        16'hC33C, 1'b1, 4'b0000, 16'h1122, 0, 1, 32'hC33CC300};
        tbl[5] = '{7'h13, 1'b1, 1, 32'h0,        16'h5555, 1'b0, 4'b0000, 16'h1122, 0, 0, 32'hFF000000};

        for (int i = 0; i < 6; i++) run_and_check($sformatf("vec%0d", i), tbl[i]);
        model_wr = 16'h1122;

        // Partial write then repeated START into a read.
        wv0 = wv_cnt; rl0 = rl_cnt;
        txn(OWN, 1'b0, 1, 32'h12000000, 1'b0, aack, ackm, rb);
        chk("partial_addr_ack", 32'(aack), 32'h1);
        chk("partial_byte_ack", 32'(ackm), 32'h1);
        chk("partial_busy_mid", 32'(BUSY), 32'h1);
        rd_data = 16'h6996;
        txn(OWN, 1'b1, 2, 32'h0, 1'b1, aack, ackm, rb);
        chk("partial_no_wr_valid", wv_cnt - wv0, 0);
        chk("partial_wr_held", 32'(WR_DATA), 32'(model_wr));
        chk("partial_read_bytes", rb, 32'h69960000);
        chk("partial_rd_load_cnt", rl_cnt - rl0, 1);

        // Randomized transactions against the model.
        for (int t = 0; t < 14; t++) begin
            v.addr = ($urandom_range(0, 3) == 0) ? 7'($urandom) : OWN;
            v.rw   = 1'($urandom);
            v.n    = $urandom_range(1, 3);
            v.wb   = $urandom;
            v.rd   = 16'($urandom);
            model(v.addr, v.rw, v.n, v.wb, v.rd, v.exp_aack, v.exp_ackm, v.exp_rb,
                  v.exp_wv, v.exp_rl);
            v.exp_wr = model_wr;
            run_and_check($sformatf("rnd%0d", t), v);
        end

        // Reset pulsed while the target is driving a read bit.
        rd_data = 16'h0000;
        bus_start();
        write_byte({OWN, 1'b1}, aack);
        chk("rst_seq_addr_ack", 32'(aack), 32'h1);
        sbit(1'b1, s);
        sbit(1'b1, s);
        wt(6);
        chk("rst_seq_driving_before", 32'(SDA_IN), 32'h1);
        RESET = 1'b1;
        wt(1);
        chk("rst_seq_outputs_next_clk", {11'h0, SDA_IN, WR_VALID, RD_LOAD, BUSY, WR_DATA}, 32'h0);
        wt(2);
        RESET = 1'b0;
        model_wr = 16'h0;
        dr0 = drv_cnt; wv0 = wv_cnt;
        for (int i = 0; i < 7; i++) sbit(1'b1, s);
        bus_stop();
        chk("rst_seq_ignored_drive", drv_cnt - dr0, 0);
        chk("rst_seq_busy", 32'(BUSY), 32'h0);
        v = '{OWN, 1'b0, 2, 32'hABCD0000, 16'h0, 1'b1, 4'b0011, 16'hABCD, 1, 0, 32'h0};
        run_and_check("after_reset", v);

        chk("sda_change_while_scl_high", viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2c_target_nb.md
I2C_TARGET_NB -- requirements
Module: i2c_target_nb

Interface
REQ-001 Parameter NBYTES, default 2: data bytes per transfer, range 1..8.
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser flops on the SCL and SDA inputs, range 2..3.
REQ-003 clk  input  1  system clock; SHALL run at least 8x the SCL frequency.
REQ-004 RESET  input  1  synchronous, active-high reset, sampled on clk.
REQ-005 SCL  input  1  bus clock, asynchronous to clk.
REQ-006 SDA_OUT  input  1  bus data as seen on the wire, asynchronous to clk.
REQ-007 I2C_ADDR  input  7  own target address, quasi-static.
REQ-008 RD_DATA  input  8*NBYTES  read payload; byte 0 is the most significant byte.
REQ-009 SDA_IN  output  1  drive SDA low when 1 (open-drain enable); 0 releases the line.
REQ-010 WR_DATA  output  8*NBYTES  last complete write payload; byte 0 is the most significant byte.
REQ-011 WR_VALID  output  1  one-clk pulse when WR_DATA updates.
REQ-012 RD_LOAD  output  1  one-clk pulse in the cycle RD_DATA is captured.
REQ-013 BUSY  output  1  high from START until STOP.

Function
REQ-014 SCL and SDA_OUT SHALL pass through SYNC_STAGES flops; all edge and condition detection SHALL use the synchronised values only.
REQ-015 START = synced SDA falls while synced SCL is high; STOP = synced SDA rises while synced SCL is high.
REQ-016 Bits SHALL be sampled on the synced SCL rising edge; SDA_IN SHALL change only in the clk cycle after a synced SCL falling edge.
REQ-017 The state machine SHALL have these states: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE.
REQ-018 START (or repeated START) in any state SHALL go to ADDR, clear the bit and byte counters, and release SDA_IN.
REQ-019 STOP in any state SHALL go to IDLE and release SDA_IN.
REQ-020 ADDR SHALL shift in 8 bits MSB first, then:
- on address match, go to ADDR_ACK and drive ACK (SDA_IN=1) for exactly one SCL period;
- on mismatch, go to IGNORE with no ACK.
REQ-021 After ADDR_ACK, the R/W bit SHALL select the next state: 0 goes to WR_BYTE, 1 goes to RD_BYTE.
REQ-022 On a read, RD_DATA SHALL be captured into a shadow register with a RD_LOAD pulse in the SCL-falling cycle that ends ADDR_ACK.
REQ-023 WR_BYTE SHALL assemble a byte MSB first, then:
- for byte index below NBYTES, ACK it;
- for byte index NBYTES or above, NACK it, with WR_DATA unchanged.
REQ-024 On the SCL falling edge ending the ACK of byte NBYTES-1, WR_DATA SHALL update atomically, with WR_VALID high for one clk.
REQ-025 Partial writes (STOP or repeated START before NBYTES bytes) SHALL be discarded: WR_DATA holds its value and there is no WR_VALID.
REQ-026 RD_BYTE SHALL drive shadow bytes MSB first (SDA_IN=1 when the bit is 0), then release SDA for the master's ACK.
REQ-027 In RD_ACK, a master ACK SHALL continue with the next byte, with the byte index wrapping from NBYTES-1 to 0; a master NACK SHALL go to IGNORE.
REQ-028 IGNORE SHALL keep SDA_IN=0 until START or STOP.
REQ-029 BUSY SHALL set on START and clear on STOP.

Reset
REQ-030 While RESET=1, the block SHALL go to IDLE and clear all counters and the shadow register.
REQ-031 While RESET=1, outputs SHALL be SDA_IN=0, WR_DATA=0, WR_VALID=0, RD_LOAD=0, BUSY=0.
REQ-032 Reset mid-transfer SHALL release SDA within one clk; the block SHALL ignore bus activity until the next START.

Structure
REQ-033 Package i2c_pkg SHALL hold the state enumeration, the address width (7), and ACK/NACK constants.
REQ-034 Sub-module i2c_bus_cond SHALL contain the synchronisers and the SCL-rise/SCL-fall/START/STOP pulse detection.

Verification
REQ-035 NBYTES=2, I2C_ADDR=0x2A: START, 0x54, 0xBE, 0xEF, STOP -> three ACKs, WR_DATA=0xBEEF, exactly one WR_VALID.
REQ-036 RD_DATA=0xA55A: START, 0x55, master ACK, master NACK, STOP -> bytes 0xA5, 0x5A on the bus, one RD_LOAD, block ends in IDLE.
REQ-037 START, 0x56 (wrong address) -> no ACK, SDA_IN=0 throughout, WR_DATA unchanged.
REQ-038 Write of 0x12 only, then repeated START and a read -> no WR_VALID, WR_DATA held, read proceeds normally.
REQ-039 Write of 3 bytes with NBYTES=2 -> third byte NACKed; read of 3 bytes with ACKs -> third byte equals byte 0.
REQ-040 RESET pulsed mid-byte -> SDA_IN=0 next clk, all outputs at reset values, next START accepted.
